// File: rtl/alu_arbiter_if.sv
// Bundle of requester, core and response signals shared by alu_arbiter and its environment.
// The arbiter takes the slave view; the requesters/core/consumer side takes the master view.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic [2:0]  req1_op;
  logic [7:0]  core_a;
  logic [7:0]  core_b;
  logic [2:0]  core_op;
  logic        core_start;
  logic [15:0] core_result;
  logic        core_busy;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        timeout_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  core_result, core_busy, rsp_ready,
    output req0_ready, req1_ready,
    output core_a, core_b, core_op, core_start,
    output rsp_valid, rsp_id, rsp_data, timeout_err
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output core_result, core_busy, rsp_ready,
    input  req0_ready, req1_ready,
    input  core_a, core_b, core_op, core_start,
    input  rsp_valid, rsp_id, rsp_data, timeout_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared ALU/UART core: one transaction in
// flight, fixed result latency, busy drain with timeout, and a held response handshake.
module alu_arbiter #(
  parameter int unsigned RESULT_LAT   = 1,
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst_n,
  input logic         ena,
  alu_arbiter_if.slave bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ISSUE    = 3'd1;
  localparam logic [2:0] WAIT_RES = 3'd2;
  localparam logic [2:0] DRAIN    = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  localparam logic [3:0] LAT_LOAD  = 4'(RESULT_LAT - 1);
  localparam logic [7:0] BUSY_LAST = 8'(BUSY_TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [7:0]  busy_cnt_q, busy_cnt_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        id_q, id_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_id_q, rsp_id_d;
  logic        timeout_q, timeout_d;

  logic grant_id;
  logic take;
  logic in_flight;

  // Contention goes to the requester that did not win last time.
  always_comb begin
    grant_id = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    take     = ena & (state_q == IDLE) & (bus.req0_valid | bus.req1_valid);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lat_cnt_d    = lat_cnt_q;
    busy_cnt_d   = busy_cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          a_d          = grant_id ? bus.req1_a  : bus.req0_a;
          b_d          = grant_id ? bus.req1_b  : bus.req0_b;
          op_d         = grant_id ? bus.req1_op : bus.req0_op;
          id_d         = grant_id;
          last_grant_d = grant_id;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        lat_cnt_d = LAT_LOAD;
        state_d   = WAIT_RES;
      end
      WAIT_RES: begin
        if (lat_cnt_q == 4'd0) begin
          rsp_data_d = bus.core_result;
          rsp_id_d   = id_q;
          state_d    = DRAIN;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      DRAIN: begin
        if (!bus.core_busy) begin
          busy_cnt_d = 8'd0;
          state_d    = RESP;
        end else if (busy_cnt_q == BUSY_LAST) begin
          busy_cnt_d = 8'd0;
          timeout_d  = 1'b1;
          state_d    = RESP;
        end else begin
          busy_cnt_d = busy_cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      lat_cnt_q    <= 4'd0;
      busy_cnt_q   <= 8'd0;
      a_q          <= 8'd0;
      b_q          <= 8'd0;
      op_q         <= 3'd0;
      id_q         <= 1'b0;
      rsp_data_q   <= 16'd0;
      rsp_id_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else if (ena) begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lat_cnt_q    <= lat_cnt_d;
      busy_cnt_q   <= busy_cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      timeout_q    <= timeout_d;
    end
  end

  assign in_flight = (state_q == ISSUE) | (state_q == WAIT_RES) | (state_q == DRAIN);

  // Ready is gated by rst_n so it reads 0 while reset is held, even with valids asserted.
  always_comb begin
    bus.req0_ready  = rst_n & take & ~grant_id;
    bus.req1_ready  = rst_n & take & grant_id;
    bus.core_a      = in_flight ? a_q  : 8'd0;
    bus.core_b      = in_flight ? b_q  : 8'd0;
    bus.core_op     = in_flight ? op_q : 3'd0;
    bus.core_start  = ena & (state_q == ISSUE);
    bus.rsp_valid   = (state_q == RESP);
    bus.rsp_id      = rsp_id_q;
    bus.rsp_data    = rsp_data_q;
    bus.timeout_err = timeout_q;
  end

endmodule
